dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Data-memory responder for the pipeline's memory stage. Accepts one load or store per request from the M stage (address, store data, byte strobes), holds the pipeline with `stall` for a fixed, parameterised number of wait states, performs the access on an internal word-organised RAM, and returns load data on `rdata`. It is the memory-side counterpart of the datapath's `memen`/`aluoutM`/`writedataM`/`readdataM` interface and replaces the zero-latency memory model with one that exercises pipeline stalls.

## Interface
- `ADDR_W`, 10: word-address bits. Depth is 2^ADDR_W 32-bit words.
- `WAIT`, 1: extra wait states per access, 0..7.

- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `memen`  in  1  request valid from the M stage.
- `memwe`  in  4  byte write strobes; `4'b0000` means load. Bit i writes `wdata[8i+7:8i]`.
- `addr`  in  32  byte address. `addr[1:0]` is ignored. Word index is `addr[ADDR_W+1:2]`.
- `wdata`  in  32  store data, already lane-aligned by the datapath.
- `rdata`  out  32  load data; registered.
- `stall`  out  1  asserted while an accepted access is outstanding.
- `addr_err`  out  1  one-cycle pulse: the access targeted an out-of-range address.

## Operation
- FSM with states IDLE, BUSY, DONE. Wait counter is 3 bits.
- IDLE:
  - `stall = memen`, combinational.
  - On `memen=1`: capture `addr`, `memwe`, `wdata`; load the counter with `WAIT`; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - `stall=1`.
  - If the counter is nonzero, decrement it.
  - If the counter is 0, perform the access at this edge and go to DONE.
    - Load: `rdata <= mem[idx]`.
    - Store: update only the strobed byte lanes; `rdata` is unchanged.
- DONE:
  - `stall=0`; `rdata` is valid; `memen` is ignored.
  - Go to IDLE unconditionally on the next edge.
- Out-of-range request (`addr[31:ADDR_W+2] != 0`):
  - No array write takes place.
  - A load sets `rdata <= 0`.
  - `addr_err=1` during the DONE cycle only.
- Repeat requests: if `memen` is still high in the IDLE cycle after DONE, that is a new request and it is accepted. A pipeline that re-presents the same store rewrites the same bytes, which is idempotent.
- Captured request fields are frozen from IDLE acceptance until DONE. Input changes during BUSY have no effect.

## Timing
- Reset values: state IDLE, counter 0, `rdata=0`, `addr_err=0`. `stall` then equals `memen`.
- RAM contents are not reset. They retain their values across `rst`.
- Reset mid-operation (BUSY or DONE):
  - Return to IDLE next edge.
  - A pending store is cancelled; the array is not written.
  - `rdata` and `addr_err` are cleared.
- Latency, with request presented in cycle 0:
  - `stall=1` in cycles 0..WAIT+1.
  - DONE is cycle WAIT+2: `stall=0`, `rdata` valid, `addr_err` valid.
  - With default `WAIT=1`: 3 stall cycles; data in cycle 3.
- `WAIT=0`: 2 stall cycles; DONE in cycle 2.
- Throughput: one access per WAIT+3 cycles under back-to-back requests.
- `rdata` holds its value until the next completing load or reset.

## Test plan
- Store, then load: reset; store `addr=0x10`, `memwe=4'b1111`, `wdata=0xDEADBEEF`. Then load `addr=0x10` -> `stall` high exactly 3 cycles per access; `rdata=0xDEADBEEF` in DONE.
- Partial store: store `memwe=4'b0010`, `wdata=0x0000AA00` to word 0x10, then load -> `rdata=0xDEADAAEF`.
- Idle bus and address alignment: `memen=0` for 5 cycles -> `stall=0`, `rdata` unchanged. Load `addr=0x13` -> same data as `addr=0x10`.
- Out-of-range access (`ADDR_W=10`):
  - Store to `addr=0x1000` -> `addr_err=1` for one cycle; a later load of `addr=0x0` is unaffected.
  - Load from `addr=0x1000` -> `rdata=0`, `addr_err` pulses.
- Reset during BUSY: store `0x12345678` to word 0x20 and assert `rst` in cycle 1 -> `stall=0`, `rdata=0`. A subsequent load of 0x20 returns the old contents, not `0x12345678`.
- Back-to-back with `WAIT=0`: `memen` held high over two loads of different addresses -> `stall` pattern 1,1,0,1,1,0; each DONE shows the correct word.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Memory-stage request/response bundle between the pipeline (master) and dmem_ctrl (slave).
// The pipeline drives the request fields; the responder returns data, stall and address-error status.
interface dmem_ctrl_if;
  logic        memen;
  logic [3:0]  memwe;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        addr_err;

  modport master (
    output memen, memwe, addr, wdata,
    input  rdata, stall, addr_err
  );

  modport slave (
    input  memen, memwe, addr, wdata,
    output rdata, stall, addr_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory responder: accepts one load/store, stalls the pipeline for WAIT extra cycles,
// then performs the access on a word-organised RAM and presents load data in a DONE cycle.
module dmem_ctrl #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 1
) (
  input logic        clk,
  input logic        rst,
  dmem_ctrl_if.slave bus
);
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [2:0] WAIT_CNT = 3'(WAIT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  state_t            nextState;
  logic [2:0]        waitCnt;
  logic [31:2]       reqWord;
  logic [3:0]        reqWe;
  logic [31:0]       reqWdata;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] reqIdx;
  logic              reqInRange;
  logic              accept;
  logic              accessNow;

  assign reqIdx     = reqWord[ADDR_W+1:2];
  assign reqInRange = (reqWord[31:ADDR_W+2] == '0);
  assign accept     = (state == IDLE) && bus.memen;
  assign accessNow  = (state == BUSY) && (waitCnt == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.memen) nextState = BUSY;
      BUSY:    if (waitCnt == 3'd0) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // stall is combinational in IDLE so the request cycle itself already holds the pipeline
  always_comb begin
    bus.stall = 1'b0;
    case (state)
      IDLE:    bus.stall = bus.memen;
      BUSY:    bus.stall = 1'b1;
      DONE:    bus.stall = 1'b0;
      default: bus.stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt      <= 3'd0;
      bus.rdata    <= '0;
      bus.addr_err <= 1'b0;
    end else begin
      bus.addr_err <= 1'b0;
      if (accept)
        waitCnt <= WAIT_CNT;
      else if ((state == BUSY) && (waitCnt != 3'd0))
        waitCnt <= waitCnt - 3'd1;
      if (accessNow) begin
        bus.addr_err <= !reqInRange;
        if (reqWe == 4'b0000)
          bus.rdata <= reqInRange ? mem[reqIdx] : '0;
      end
    end
  end

  // request fields are frozen from acceptance until DONE; they carry no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      reqWord  <= bus.addr[31:2];
      reqWe    <= bus.memwe;
      reqWdata <= bus.wdata;
    end
  end

  // a reset arriving on the access edge cancels the store; RAM itself is never cleared
  always_ff @(posedge clk) begin
    if (accessNow && !rst && reqInRange) begin
      for (int b = 0; b < 4; b++) begin
        if (reqWe[b]) mem[reqIdx][8*b +: 8] <= reqWdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (WAIT=0 and WAIT=1) share one stimulus stream and are
// compared every cycle against a transaction-timeline model, plus literal directed expectations.
module tb_dmem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        memen;
  logic [3:0]  memwe;
  logic [31:0] addr;
  logic [31:0] wdata;

  int checks   = 0;
  int failures = 0;

  dmem_ctrl_if bus0 ();
  dmem_ctrl_if bus1 ();

  assign bus0.memen = memen;
  assign bus0.memwe = memwe;
  assign bus0.addr  = addr;
  assign bus0.wdata = wdata;
  assign bus1.memen = memen;
  assign bus1.memwe = memwe;
  assign bus1.addr  = addr;
  assign bus1.wdata = wdata;

  dmem_ctrl #(.ADDR_W(10), .WAIT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  dmem_ctrl #(.ADDR_W(10), .WAIT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pre(input int i);
    return {8'(i), 8'hC3, 8'(i * 7), 8'h5A};
  endfunction

  // ---------------- reference model: each accepted request completes at a fixed cycle offset
  logic [31:0] refMem [2][1024];
  bit          mBusy [2];
  bit          mDone [2];
  int          accessCyc [2];
  logic [31:0] mAddr [2];
  logic [31:0] mWdata [2];
  logic [3:0]  mWe [2];
  logic [31:0] mRdata [2];
  bit          mErr [2];
  int          cyc = 0;
  bit          modelReady = 0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int          idx;
      bit          inRange;
      logic [31:0] mask;
      if (rst) begin
        mBusy[d] = 0; mDone[d] = 0; mRdata[d] = '0; mErr[d] = 0;
        modelReady = 1;
      end else if (mDone[d]) begin
        mDone[d] = 0; mErr[d] = 0;
      end else if (mBusy[d]) begin
        if (cyc == accessCyc[d]) begin
          idx     = int'((mAddr[d] >> 2) & 32'd1023);
          inRange = (mAddr[d] >> 12) == 0;
          if (mWe[d] == 4'b0000) begin
            mRdata[d] = inRange ? refMem[d][idx] : 32'h0;
          end else if (inRange) begin
            mask = {{8{mWe[d][3]}}, {8{mWe[d][2]}}, {8{mWe[d][1]}}, {8{mWe[d][0]}}};
            refMem[d][idx] = (refMem[d][idx] & ~mask) | (mWdata[d] & mask);
          end
          mErr[d]  = !inRange;
          mBusy[d] = 0;
          mDone[d] = 1;
        end
      end else if (memen) begin
        mAddr[d] = addr; mWe[d] = memwe; mWdata[d] = wdata;
        mBusy[d] = 1;
        accessCyc[d] = cyc + d + 1;   // instance d has WAIT=d
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (modelReady) begin
      for (int d = 0; d < 2; d++) begin
        logic        actStall;
        logic        actErr;
        logic [31:0] actRdata;
        actStall = (d == 0) ? bus0.stall    : bus1.stall;
        actErr   = (d == 0) ? bus0.addr_err : bus1.addr_err;
        actRdata = (d == 0) ? bus0.rdata    : bus1.rdata;
        check($sformatf("model_stall%0d", d), {31'b0, actStall},
              {31'b0, mBusy[d] || (!mDone[d] && memen)});
        check($sformatf("model_addr_err%0d", d), {31'b0, actErr}, {31'b0, mErr[d]});
        check($sformatf("model_rdata%0d", d), actRdata, mRdata[d]);
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                        output int nStall, output logic [31:0] rd, output logic err);
    @(posedge clk); #1;
    memen = 1'b1; addr = a; memwe = we; wdata = wd;
    nStall = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus1.stall) nStall++;
      else break;
    end
    rd  = bus1.rdata;
    err = bus1.addr_err;
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    memen = 1'b0;
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    if ($urandom_range(0, 7) == 0)
      a = (32'($urandom_range(1, 32'hFFFFF)) << 12) | 32'($urandom_range(0, 4095));
    else
      a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
    return a;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] rd;
    logic        err;
    logic [5:0]  pat;
    logic [31:0] b2bA;
    logic [31:0] b2bB;

    rst = 1'b1; memen = 1'b0; memwe = 4'b0; addr = '0; wdata = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    check("reset_stall", {31'b0, bus1.stall}, 32'd0);
    check("reset_rdata", bus1.rdata, 32'd0);
    check("reset_addr_err", {31'b0, bus1.addr_err}, 32'd0);

    for (int i = 0; i < 64; i++) access(32'(i) << 2, 4'hF, pre(i), n, rd, err);

    access(32'h10, 4'b1111, 32'hDEADBEEF, n, rd, err);
    check("store_stall_cycles", n, 3);
    check("store_addr_err", {31'b0, err}, 32'd0);
    access(32'h10, 4'b0000, 32'h0, n, rd, err);
    check("load_stall_cycles", n, 3);
    check("load_rdata", rd, 32'hDEADBEEF);

    access(32'h10, 4'b0010, 32'h0000AA00, n, rd, err);
    access(32'h10, 4'b0000, 32'h0, n, rd, err);
    check("partial_store_rdata", rd, 32'hDEADAAEF);

    idle(5);
    @(negedge clk);
    check("idle_stall", {31'b0, bus1.stall}, 32'd0);
    check("idle_rdata_held", bus1.rdata, 32'hDEADAAEF);
    access(32'h13, 4'b0000, 32'h0, n, rd, err);
    check("unaligned_load", rd, 32'hDEADAAEF);

    access(32'h1000, 4'b1111, 32'hFFFFFFFF, n, rd, err);
    check("oor_store_addr_err", {31'b0, err}, 32'd1);
    check("oor_store_rdata_kept", rd, 32'hDEADAAEF);
    idle(1);
    @(negedge clk);
    check("oor_addr_err_pulse", {31'b0, bus1.addr_err}, 32'd0);
    access(32'h0, 4'b0000, 32'h0, n, rd, err);
    check("word0_after_oor", rd, pre(0));
    access(32'h1000, 4'b0000, 32'h0, n, rd, err);
    check("oor_load_rdata", rd, 32'd0);
    check("oor_load_addr_err", {31'b0, err}, 32'd1);

    idle(3);
    @(posedge clk); #1;
    memen = 1'b1; addr = 32'h20; memwe = 4'hF; wdata = 32'h12345678;
    @(posedge clk); #1;
    rst = 1'b1; memen = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy_stall1", {31'b0, bus1.stall}, 32'd0);
    check("rst_busy_rdata1", bus1.rdata, 32'd0);
    check("rst_busy_stall0", {31'b0, bus0.stall}, 32'd0);
    check("rst_busy_rdata0", bus0.rdata, 32'd0);
    access(32'h20, 4'b0000, 32'h0, n, rd, err);
    check("rst_cancelled_store", rd, pre(8));

    idle(3);
    b2bA = '0; b2bB = '0; pat = '0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin memen = 1'b1; addr = 32'h10; memwe = 4'b0000; end
      if (c == 3) addr = 32'h20;
      @(negedge clk);
      pat[5 - c] = bus0.stall;
      if (c == 2) b2bA = bus0.rdata;
      if (c == 5) b2bB = bus0.rdata;
    end
    check("b2b_stall_pattern", {26'b0, pat}, 32'b110110);
    check("b2b_first_load", b2bA, 32'hDEADAAEF);
    check("b2b_second_load", b2bB, pre(8));
    idle(4);

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      rst   = ($urandom_range(0, 49) == 0);
      memen = ($urandom_range(0, 2) != 0);
      addr  = randAddr();
      memwe = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      wdata = $urandom;
    end
    @(posedge clk); #1;
    rst = 1'b0; memen = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
